dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have port iClk, in, 1: sole clock, rising edge.
REQ-002 SHALL have port iReset_n, in, 1: asynchronous, active-low reset.
REQ-003 SHALL have ports iCpuReq / iDbgReq, in, 1: access request from the CPU load/store stage or the debug/loader port.
REQ-004 SHALL have ports iCpuWr / iDbgWr, in, 1: 1 = write, 0 = read; valid while Req=1.
REQ-005 SHALL have ports iCpuAddr / iDbgAddr, in, `ADDR_W: word address.
REQ-006 SHALL have ports iCpuWrData / iDbgWrData, in, `DATA_W: write data.
REQ-007 SHALL have ports oCpuGnt / oDbgGnt, out, 1: one-cycle pulse, request consumed.
REQ-008 SHALL have ports oCpuRdValid / oDbgRdValid, out, 1: one-cycle pulse, read data valid.
REQ-009 SHALL have ports oCpuRdData / oDbgRdData, out, `DATA_W: read data, held until that requester's next read.
REQ-010 SHALL have port oMemAddr, out, `ADDR_W: data-memory address.
REQ-011 SHALL have port oMemWrData, out, `DATA_W: data-memory write data.
REQ-012 SHALL have ports oMemWr / oMemRd, out, 1: data-memory strobes; never both 1.
REQ-013 SHALL have port iMemRdData, in, `DATA_W: data-memory read data, valid in the cycle oMemRd=1.
REQ-014 SHALL have port oBusy, out, 1: FSM not in IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-016 IDLE: if any Req=1 at a rising edge, SHALL latch the winner's Wr, Addr and WrData into registers and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-017 ACCESS (exactly 1 cycle) SHALL drive oMemAddr and oMemWrData from the latched values, drive oMemWr=Wr and oMemRd=!Wr, and pulse the winner's Gnt.
REQ-018 From ACCESS, a write SHALL return to IDLE; a read SHALL capture iMemRdData at the closing edge and go to RESP.
REQ-019 RESP (exactly 1 cycle) SHALL pulse the winner's RdValid with RdData updated, then go to IDLE.
REQ-020 Latency, Req sampled at edge N: Gnt and strobe SHALL occur in cycle N+1; read RdValid SHALL occur in cycle N+2. Peak throughput is one access per 2 cycles (write) or 3 cycles (read).
REQ-021 A requester SHALL hold Req, Wr, Addr and WrData stable until its Gnt; changes after the latch edge SHALL be ignored.
REQ-022 A Req deasserted before being sampled in IDLE SHALL produce no access.
REQ-023 Both Req=1 in IDLE: the winner SHALL be decided per REQ-028/029; the loser SHALL stay pending, with no Gnt.
REQ-024 Outside ACCESS: oMemWr=oMemRd=0, and oMemAddr and oMemWrData SHALL hold their last values.
REQ-025 Addresses SHALL pass through unmodified; there is no range check and no wrap logic.

Reset
REQ-026 While iReset_n=0, SHALL force state=IDLE; all Gnt, RdValid, oMemWr, oMemRd and oBusy=0; all RdData, oMemAddr and oMemWrData=0; round-robin pointer = Cpu. This SHALL take effect immediately, independent of iClk.
REQ-027 Reset asserted mid-ACCESS or mid-RESP SHALL abort the access: no Gnt or RdValid pulse after release; the requester re-issues.

Configuration
REQ-028 With DMEM_ARB_RR_EN defined: round-robin arbitration. The pointer SHALL toggle to the non-winner after each grant; on a tie, the pointed requester wins.
REQ-029 Without DMEM_ARB_RR_EN: fixed priority, Cpu SHALL always beat Dbg on a tie; no pointer register exists.

Structure
REQ-030 `ADDR_W, `DATA_W and the state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) SHALL live in the shared defines include.
REQ-031 The winner selection (reqs, pointer -> one-hot grant) SHALL be one combinational sub-module, dmem_arb_pick.

Verification
REQ-032 Cpu write: addr=0x10, data=0xDEADBEEF -> cycle N+1: oMemWr=1, oMemAddr=0x10, oCpuGnt=1; cycle N+2: IDLE, oBusy=0.
REQ-033 Cpu read of addr 0x10 with memory model returning 0xDEADBEEF -> N+1: oMemRd=1, oCpuGnt=1; N+2: oCpuRdValid=1, oCpuRdData=0xDEADBEEF.
REQ-034 Both Req=1 held, reads, fixed-priority build -> grant order Cpu,Cpu,Cpu...; Dbg starved until iCpuReq=0.
REQ-035 Same stimulus, DMEM_ARB_RR_EN build -> grant order Cpu,Dbg,Cpu,Dbg; never oMemWr&oMemRd.
REQ-036 iReset_n pulled low during ACCESS of a Dbg read -> outputs 0 immediately; after release, no oDbgRdValid until Dbg re-requests.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared defines and package for the data-memory arbiter.
//                The defines block holds the bus widths (`ADDR_W, `DATA_W)
//                and the FSM state encodings. The package republishes them
//                as typed localparams and the state enum.
//                Optional feature macro: DMEM_ARB_RR_EN (round-robin
//                arbitration). It is consumed by dmem_arbiter.sv.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef DMEM_ARBITER_DEFINES
`define DMEM_ARBITER_DEFINES
`define ADDR_W    16
`define DATA_W    32
`define ST_IDLE   2'd0
`define ST_ACCESS 2'd1
`define ST_RESP   2'd2
`endif

package dmem_arbiter_pkg;

  localparam int ADDR_WIDTH = `ADDR_W;
  localparam int DATA_WIDTH = `DATA_W;

  typedef enum logic [1:0] {
    IDLE   = `ST_IDLE,
    ACCESS = `ST_ACCESS,
    RESP   = `ST_RESP
  } arbStateT;

  // One-hot grant vector from the picker: bit 0 = Cpu, bit 1 = Dbg.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DBG  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the requester, response and data-memory signals
//                around the data-memory arbiter.
//                master : requesters and memory model (drive i*, observe o*)
//                slave  : the arbiter (observe i*, drive o*)
//  Ports       : Cpu/Dbg Req, Wr, Addr, WrData in; Gnt, RdValid, RdData out;
//                memory Addr, WrData, Wr, Rd out; memory RdData in; Busy out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  // Requester side
  logic                  iCpuReq;
  logic                  iCpuWr;
  logic [ADDR_WIDTH-1:0] iCpuAddr;
  logic [DATA_WIDTH-1:0] iCpuWrData;
  logic                  iDbgReq;
  logic                  iDbgWr;
  logic [ADDR_WIDTH-1:0] iDbgAddr;
  logic [DATA_WIDTH-1:0] iDbgWrData;

  // Responses
  logic                  oCpuGnt;
  logic                  oDbgGnt;
  logic                  oCpuRdValid;
  logic                  oDbgRdValid;
  logic [DATA_WIDTH-1:0] oCpuRdData;
  logic [DATA_WIDTH-1:0] oDbgRdData;

  // Data-memory side
  logic [ADDR_WIDTH-1:0] oMemAddr;
  logic [DATA_WIDTH-1:0] oMemWrData;
  logic                  oMemWr;
  logic                  oMemRd;
  logic [DATA_WIDTH-1:0] iMemRdData;

  logic                  oBusy;

  modport master (
    output iCpuReq, iCpuWr, iCpuAddr, iCpuWrData,
    output iDbgReq, iDbgWr, iDbgAddr, iDbgWrData,
    output iMemRdData,
    input  oCpuGnt, oDbgGnt, oCpuRdValid, oDbgRdValid,
    input  oCpuRdData, oDbgRdData,
    input  oMemAddr, oMemWrData, oMemWr, oMemRd, oBusy
  );

  modport slave (
    input  iCpuReq, iCpuWr, iCpuAddr, iCpuWrData,
    input  iDbgReq, iDbgWr, iDbgAddr, iDbgWrData,
    input  iMemRdData,
    output oCpuGnt, oDbgGnt, oCpuRdValid, oDbgRdValid,
    output oCpuRdData, oDbgRdData,
    output oMemAddr, oMemWrData, oMemWr, oMemRd, oBusy
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pick
//  Description : Combinational winner selection for the data-memory arbiter.
//                A lone request always wins; on a tie the requester named
//                by iPtrDbg wins (0 = Cpu, 1 = Dbg).
//  Ports       : iCpuReq, iDbgReq - pending requests
//                iPtrDbg          - tie-break pointer
//                oGnt             - one-hot winner {Dbg, Cpu}, 0 if none
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic       iCpuReq,
  input  logic       iDbgReq,
  input  logic       iPtrDbg,
  output logic [1:0] oGnt
);

  always_comb begin
    oGnt = GNT_NONE;
    if (iCpuReq && iDbgReq) begin
      oGnt = iPtrDbg ? GNT_DBG : GNT_CPU;
    end else if (iCpuReq) begin
      oGnt = GNT_CPU;
    end else if (iDbgReq) begin
      oGnt = GNT_DBG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester (Cpu, Dbg) arbiter in front of a single-port
//                data memory. IDLE latches the winning request, ACCESS drives
//                the memory for one cycle and pulses the winner's Gnt, and
//                RESP (reads only) pulses the winner's RdValid.
//                Build option DMEM_ARB_RR_EN: round-robin tie-break; without
//                it Cpu has fixed priority over Dbg.
//  Ports       : iClk     - clock, rising edge
//                iReset_n - asynchronous active-low reset
//                bus      - dmem_arbiter_if.slave (requests, responses,
//                           data-memory strobes, busy flag)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic          iClk,
  input  logic          iReset_n,
  dmem_arbiter_if.slave bus
);

  arbStateT              state;
  arbStateT              nextState;
  logic [1:0]            pickGnt;
  logic                  ptrDbg;
  logic                  latchEn;
  logic                  captureEn;

  logic                  winDbg;      // latched winner: 1 = Dbg, 0 = Cpu
  logic                  latWr;       // latched Wr of the winner
  logic [ADDR_WIDTH-1:0] memAddr;     // doubles as the latched address
  logic [DATA_WIDTH-1:0] memWrData;   // doubles as the latched write data
  logic [DATA_WIDTH-1:0] cpuRdData;
  logic [DATA_WIDTH-1:0] dbgRdData;

  logic                  memWr;
  logic                  memRd;
  logic                  cpuGnt;
  logic                  dbgGnt;
  logic                  cpuRdValid;
  logic                  dbgRdValid;

  dmem_arb_pick uPick (
    .iCpuReq (bus.iCpuReq),
    .iDbgReq (bus.iDbgReq),
    .iPtrDbg (ptrDbg),
    .oGnt    (pickGnt)
  );

`ifdef DMEM_ARB_RR_EN
  // Pointer moves to the non-winner as the grant is issued. An access
  // aborted by reset never reaches that point, and reset puts it on Cpu.
  logic rrPtr;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rrPtr <= 1'b0;
    end else if (state == ACCESS) begin
      rrPtr <= ~winDbg;
    end
  end

  assign ptrDbg = rrPtr;
`else
  assign ptrDbg = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    nextState  = state;
    latchEn    = 1'b0;
    captureEn  = 1'b0;
    memWr      = 1'b0;
    memRd      = 1'b0;
    cpuGnt     = 1'b0;
    dbgGnt     = 1'b0;
    cpuRdValid = 1'b0;
    dbgRdValid = 1'b0;

    unique case (state)
      IDLE: begin
        if (pickGnt != GNT_NONE) begin
          latchEn   = 1'b1;
          nextState = ACCESS;
        end
      end

      ACCESS: begin
        memWr  = latWr;
        memRd  = ~latWr;
        cpuGnt = ~winDbg;
        dbgGnt = winDbg;
        if (latWr) begin
          nextState = IDLE;
        end else begin
          captureEn = 1'b1;
          nextState = RESP;
        end
      end

      RESP: begin
        cpuRdValid = ~winDbg;
        dbgRdValid = winDbg;
        nextState  = IDLE;
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch and read-data capture. The memory address/data registers
  // are loaded only on the latch edge, so they present the latched request
  // during ACCESS and hold their last value everywhere else.
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      winDbg    <= 1'b0;
      latWr     <= 1'b0;
      memAddr   <= '0;
      memWrData <= '0;
      cpuRdData <= '0;
      dbgRdData <= '0;
    end else begin
      if (latchEn) begin
        winDbg    <= pickGnt[1];
        latWr     <= pickGnt[1] ? bus.iDbgWr     : bus.iCpuWr;
        memAddr   <= pickGnt[1] ? bus.iDbgAddr   : bus.iCpuAddr;
        memWrData <= pickGnt[1] ? bus.iDbgWrData : bus.iCpuWrData;
      end
      if (captureEn) begin
        if (winDbg) begin
          dbgRdData <= bus.iMemRdData;
        end else begin
          cpuRdData <= bus.iMemRdData;
        end
      end
    end
  end

  assign bus.oMemAddr    = memAddr;
  assign bus.oMemWrData  = memWrData;
  assign bus.oMemWr      = memWr;
  assign bus.oMemRd      = memRd;
  assign bus.oCpuGnt     = cpuGnt;
  assign bus.oDbgGnt     = dbgGnt;
  assign bus.oCpuRdValid = cpuRdValid;
  assign bus.oDbgRdValid = dbgRdValid;
  assign bus.oCpuRdData  = cpuRdData;
  assign bus.oDbgRdData  = dbgRdData;
  assign bus.oBusy       = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Stimulus pushes the
//                expected Gnt / RdValid events into a queue; a monitor on the
//                falling edge pops and compares every pulse the DUT presents.
//                A small word memory answers the DUT's read strobes.
//                Follows the DMEM_ARB_RR_EN build option for the contention
//                expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct packed {
    logic                  isRdv;
    logic                  isDbg;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } expT;

  logic clk = 1'b0;
  logic rstN;
  expT  expQ[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .iClk     (clk),
    .iReset_n (rstN),
    .bus      (bus)
  );

  // Memory model: writes land at the closing edge of ACCESS, reads are
  // combinational while oMemRd is high.
  logic [DATA_WIDTH-1:0] memArr [256];

  always @(posedge clk) begin
    if (bus.oMemWr) memArr[bus.oMemAddr[7:0]] <= bus.oMemWrData;
  end

  assign bus.iMemRdData = bus.oMemRd ? memArr[bus.oMemAddr[7:0]] : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic pushExp(input logic rdv, input logic dbg, input logic wr,
                         input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data);
    expT e;
    e.isRdv = rdv; e.isDbg = dbg; e.wr = wr; e.addr = addr; e.data = data;
    expQ.push_back(e);
  endtask

  task automatic checkEvent(input logic rdv, input logic dbg);
    expT                   e;
    logic [DATA_WIDTH-1:0] got;
    tests++;
    if (expQ.size() == 0) begin
      fails++;
      $display("FAIL unexpected %s pulse from %s (none required)", rdv ? "RdValid" : "Gnt", dbg ? "Dbg" : "Cpu");
      return;
    end
    e = expQ.pop_front();
    if (rdv) begin
      got = dbg ? bus.oDbgRdData : bus.oCpuRdData;
      if (e.isRdv !== 1'b1 || e.isDbg !== dbg || got !== e.data) begin
        fails++;
        $display("FAIL rdvalid: got kind=rdv dbg=%0d data=%h, required kind=%s dbg=%0d data=%h",
                 dbg, got, e.isRdv ? "rdv" : "gnt", e.isDbg, e.data);
      end
    end else begin
      if (e.isRdv !== 1'b0 || e.isDbg !== dbg || bus.oMemAddr !== e.addr ||
          bus.oMemWr !== e.wr || bus.oMemRd !== !e.wr ||
          (e.wr && bus.oMemWrData !== e.data)) begin
        fails++;
        $display("FAIL grant: got kind=gnt dbg=%0d wr=%0d rd=%0d addr=%h wdata=%h, required kind=%s dbg=%0d wr=%0d addr=%h wdata=%h",
                 dbg, bus.oMemWr, bus.oMemRd, bus.oMemAddr, bus.oMemWrData,
                 e.isRdv ? "rdv" : "gnt", e.isDbg, e.wr, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every pulse the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      tests++;
      if ((bus.oMemWr && bus.oMemRd) || (bus.oCpuGnt && bus.oDbgGnt)) begin
        fails++;
        $display("FAIL exclusivity: memWr=%0d memRd=%0d cpuGnt=%0d dbgGnt=%0d, required no pair both 1",
                 bus.oMemWr, bus.oMemRd, bus.oCpuGnt, bus.oDbgGnt);
      end
      if (bus.oCpuGnt || bus.oDbgGnt)         checkEvent(1'b0, bus.oDbgGnt);
      if (bus.oCpuRdValid || bus.oDbgRdValid) checkEvent(1'b1, bus.oDbgRdValid);
    end
  end

  task automatic setReq(input logic dbg, input logic req, input logic wr,
                        input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data);
    if (dbg) begin
      bus.iDbgReq = req; bus.iDbgWr = wr; bus.iDbgAddr = addr; bus.iDbgWrData = data;
    end else begin
      bus.iCpuReq = req; bus.iCpuWr = wr; bus.iCpuAddr = addr; bus.iCpuWrData = data;
    end
  endtask

  // Requester: holds Req for `count` back-to-back grants, drops it after
  // the edge that closes the last grant's ACCESS cycle.
  task automatic doReq(input logic dbg, input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                       input logic [DATA_WIDTH-1:0] data, input int count);
    int waitCyc;
    @(negedge clk);
    setReq(dbg, 1'b1, wr, addr, data);
    for (int n = 0; n < count; n++) begin
      waitCyc = 0;
      while (!(dbg ? bus.oDbgGnt : bus.oCpuGnt) && waitCyc < 40) begin
        @(negedge clk);
        waitCyc++;
      end
      tests++;
      if (waitCyc >= 40) begin
        fails++;
        $display("FAIL grant timeout %s: waited %0d cycles, required grant within 40", dbg ? "Dbg" : "Cpu", waitCyc);
        break;
      end
      @(posedge clk);
      if (n == count - 1) begin
        #1;
      end else begin
        @(negedge clk);
      end
    end
    setReq(dbg, 1'b0, 1'b0, '0, '0);
  endtask

  int rdvCount;
  int drain;

  initial begin
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    rstN = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset oBusy",      bus.oBusy, 0);
    chk("reset strobes",    {bus.oMemWr, bus.oMemRd}, 0);
    chk("reset gnt/rdv",    {bus.oCpuGnt, bus.oDbgGnt, bus.oCpuRdValid, bus.oDbgRdValid}, 0);
    chk("reset oMemAddr",   bus.oMemAddr, 0);
    chk("reset oMemWrData", bus.oMemWrData, 0);
    chk("reset rdData",     {bus.oCpuRdData, bus.oDbgRdData}, 0);
    rstN = 1'b1;
    @(negedge clk);

    // Cpu write 0x10 <- DEADBEEF with cycle-exact latency
    pushExp(0, 0, 1, 16'h0010, 32'hDEADBEEF);
    setReq(1'b0, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    chk("wr N+1 gnt/wr/addr", {bus.oCpuGnt, bus.oMemWr, bus.oMemRd, bus.oMemAddr}, {3'b110, 16'h0010});
    @(posedge clk); #1 setReq(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("wr N+2 busy", {bus.oBusy, bus.oMemWr}, 0);
    chk("hold oMemAddr", bus.oMemAddr, 16'h0010);

    // Cpu read 0x10 -> DEADBEEF
    pushExp(0, 0, 0, 16'h0010, '0);
    pushExp(1, 0, 0, '0, 32'hDEADBEEF);
    setReq(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("rd N+1 gnt/rd", {bus.oCpuGnt, bus.oMemRd, bus.oMemWr}, 3'b110);
    @(posedge clk); #1 setReq(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rd N+2 rdvalid/data", {bus.oCpuRdValid, bus.oCpuRdData}, {1'b1, 32'hDEADBEEF});
    @(negedge clk);
    chk("rd N+3 busy/rdvalid", {bus.oBusy, bus.oCpuRdValid}, 0);
    chk("rd data held", bus.oCpuRdData, 32'hDEADBEEF);

    // Dbg write/read and preload of the contention words
    pushExp(0, 1, 1, 16'h0020, 32'h12345678);
    doReq(1'b1, 1'b1, 16'h0020, 32'h12345678, 1);
    pushExp(0, 1, 0, 16'h0020, '0);
    pushExp(1, 1, 0, '0, 32'h12345678);
    doReq(1'b1, 1'b0, 16'h0020, '0, 1);
    pushExp(0, 0, 1, 16'h0030, 32'hA5A5A5A5);
    doReq(1'b0, 1'b1, 16'h0030, 32'hA5A5A5A5, 1);
    pushExp(0, 1, 1, 16'h0040, 32'h5A5A5A5A);
    doReq(1'b1, 1'b1, 16'h0040, 32'h5A5A5A5A, 1);
    repeat (2) @(negedge clk);

    // A pulse of Req that no edge samples must produce nothing
    @(posedge clk); #1 setReq(1'b0, 1'b1, 1'b1, 16'h0050, 32'h1);
    @(negedge clk);    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("unsampled req busy", bus.oBusy, 0);

    // Contention: both requesters hold read requests
`ifdef DMEM_ARB_RR_EN
    for (int k = 0; k < 2; k++) begin
      pushExp(0, 0, 0, 16'h0030, '0); pushExp(1, 0, 0, '0, 32'hA5A5A5A5);
      pushExp(0, 1, 0, 16'h0040, '0); pushExp(1, 1, 0, '0, 32'h5A5A5A5A);
    end
    fork
      doReq(1'b0, 1'b0, 16'h0030, '0, 2);
      doReq(1'b1, 1'b0, 16'h0040, '0, 2);
    join
`else
    for (int k = 0; k < 3; k++) begin
      pushExp(0, 0, 0, 16'h0030, '0); pushExp(1, 0, 0, '0, 32'hA5A5A5A5);
    end
    pushExp(0, 1, 0, 16'h0040, '0); pushExp(1, 1, 0, '0, 32'h5A5A5A5A);
    fork
      doReq(1'b0, 1'b0, 16'h0030, '0, 3);
      doReq(1'b1, 1'b0, 16'h0040, '0, 1);
    join
`endif
    repeat (3) @(negedge clk);

    // Reset during ACCESS of a Dbg read
    setReq(1'b1, 1'b1, 1'b0, 16'h0020, '0);
    @(posedge clk); #1;
    chk("abort pre busy", bus.oBusy, 1);
    rstN = 1'b0;
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("abort gnt/strobes/busy", {bus.oDbgGnt, bus.oMemRd, bus.oMemWr, bus.oBusy}, 0);
    chk("abort oMemAddr", bus.oMemAddr, 0);
    chk("abort oDbgRdData", bus.oDbgRdData, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    rdvCount = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.oDbgRdValid) rdvCount++;
    end
    chk("abort no rdvalid", rdvCount, 0);

    // Dbg re-issues the aborted read
    pushExp(0, 1, 0, 16'h0020, '0);
    pushExp(1, 1, 0, '0, 32'h12345678);
    doReq(1'b1, 1'b0, 16'h0020, '0, 1);

    drain = 0;
    while (expQ.size() != 0 && drain < 50) begin
      @(negedge clk);
      drain++;
    end
    chk("queue drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
